// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-master memory bus arbiter.
// Optional lock-timeout feature is enabled by defining ARB_LOCK_TIMEOUT_EN.
package mem_arb_pkg;

    // Default widths of the Memory address and data buses
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Default cap on consecutive locked cycles while the other master waits
    localparam int LOCK_MAX_DEF = 15;

    // Base of the 16 memory-mapped registers decoded inside Memory
    localparam logic [15:0] MMIO_BASE = 16'h1FF0;

    // Bus ownership states; grants are decoded straight from these
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_port_mux.sv
// Selects the owning master's request, write enable, address and write
// data onto the single Memory port based on the arbiter state.
// Everything not owned (or owned but idle) drives zeros so Memory
// never sees a stale address or a spurious load.
module mem_arb_port_mux
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  arb_state_t        state,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              sel_req,
    output logic              sel_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_load,
    output logic [DATA_W-1:0] mem_in
);

    // Route the owner's access to Memory only while it is actually requesting
    always_comb begin
        sel_req     = 1'b0;
        sel_we      = 1'b0;
        mem_address = '0;
        mem_in      = '0;
        case (state)
            OWN_A: begin
                sel_req = a_req;
                sel_we  = a_we;
                if (a_req) begin
                    mem_address = a_addr;
                    mem_in      = a_wdata;
                end
            end
            OWN_B: begin
                sel_req = b_req;
                sel_we  = b_we;
                if (b_req) begin
                    mem_address = b_addr;
                    mem_in      = b_wdata;
                end
            end
            default: begin
            end
        endcase
        mem_load = sel_req & sel_we;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single Memory port: master A (CPU data port)
// and master B (DMA / I/O engine). Round-robin between contending masters,
// optional bus lock for bursts, registered read-data return per master.
// Define ARB_LOCK_TIMEOUT_EN to bound how long a lock may starve the other
// master (LOCK_MAX cycles) and pulse lock_abort on the forced handoff.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_load,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out,
    output logic              lock_abort
);

    if (LOCK_MAX < 1) begin : g_lock_max_check
        $error("mem_bus_arbiter: LOCK_MAX must be at least 1");
    end

    arb_state_t state;
    arb_state_t state_nxt;
    logic       favour_b;
    logic       sel_req;
    logic       sel_we;
    logic       force_handoff;
    logic       a_read;
    logic       b_read;

    mem_arb_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_mux (
        .state       (state),
        .a_req       (a_req),
        .a_we        (a_we),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .b_req       (b_req),
        .b_we        (b_we),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .sel_req     (sel_req),
        .sel_we      (sel_we),
        .mem_address (mem_address),
        .mem_load    (mem_load),
        .mem_in      (mem_in)
    );

    assign a_gnt  = (state == OWN_A);
    assign b_gnt  = (state == OWN_B);
    assign a_read = (state == OWN_A) && sel_req && !sel_we;
    assign b_read = (state == OWN_B) && sel_req && !sel_we;

`ifdef ARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = ($clog2(LOCK_MAX + 1) > 4) ? $clog2(LOCK_MAX + 1) : 4;

    logic [CNT_W-1:0] lock_cnt;
    logic             locked_wait;

    // A locked, still-requesting owner is holding off the other master
    always_comb begin
        locked_wait = 1'b0;
        case (state)
            OWN_A:   locked_wait = a_req & a_lock & b_req;
            OWN_B:   locked_wait = b_req & b_lock & a_req;
            default: locked_wait = 1'b0;
        endcase
    end

    // The LOCK_MAX-th consecutive locked cycle is the last one the owner gets
    assign force_handoff = locked_wait && (lock_cnt == CNT_W'(LOCK_MAX - 1));

    // Count locked cycles; any ownership change or idle waiter restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
        end else if ((state_nxt != state) || !locked_wait) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt + 1'b1;
        end
    end

    // Flag the first cycle of a grant that was taken away from a lock holder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_abort <= 1'b0;
        end else begin
            lock_abort <= force_handoff;
        end
    end
`else
    assign force_handoff = 1'b0;
    assign lock_abort    = 1'b0;
`endif

    // Ownership register; reset drops grants and mem_load immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next owner: keep a locked or uncontested owner, otherwise hand over directly
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (a_req && b_req) begin
                    state_nxt = favour_b ? OWN_B : OWN_A;
                end else if (a_req) begin
                    state_nxt = OWN_A;
                end else if (b_req) begin
                    state_nxt = OWN_B;
                end else begin
                    state_nxt = IDLE;
                end
            end
            OWN_A: begin
                if (a_req && (a_lock || !b_req) && !force_handoff) begin
                    state_nxt = OWN_A;
                end else if (b_req) begin
                    state_nxt = OWN_B;
                end else begin
                    state_nxt = IDLE;
                end
            end
            OWN_B: begin
                if (b_req && (b_lock || !a_req) && !force_handoff) begin
                    state_nxt = OWN_B;
                end else if (a_req) begin
                    state_nxt = OWN_A;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Remember who was served last so a tie from IDLE goes to the other one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour_b <= 1'b0;
        end else if (state_nxt != state) begin
            if (state == OWN_A) begin
                favour_b <= 1'b1;
            end else if (state == OWN_B) begin
                favour_b <= 1'b0;
            end
        end
    end

    // Capture Memory's combinational read data at the end of A's read cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            a_rdata  <= '0;
        end else begin
            a_rvalid <= a_read;
            if (a_read) begin
                a_rdata <= mem_out;
            end
        end
    end

    // Capture Memory's combinational read data at the end of B's read cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_rvalid <= 1'b0;
            b_rdata  <= '0;
        end else begin
            b_rvalid <= b_read;
            if (b_read) begin
                b_rdata <= mem_out;
            end
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter sharing the single Memory port between master A (CPU data port) and master B (DMA / I/O engine).
- Sits between the masters and the Memory block's address/load/in/out pins. Memory decodes RAM versus the 16 memory-mapped registers at 0x1FF0–0x1FFF itself.
- Provides round-robin fairness, optional bus lock for multi-word transfers, and registered read-data return.

Parameters:
- ADDR_W, 16, address width to Memory.
- DATA_W, 16, data width.
- LOCK_MAX, 15, maximum consecutive locked cycles while the other master waits (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  master A requests an access this cycle
- a_we  in  1  1 = write, 0 = read
- a_lock  in  1  keep the grant after the current access
- a_addr  in  ADDR_W  access address
- a_wdata  in  DATA_W  write data
- a_gnt  out  1  A owns the bus
- a_rvalid  out  1  read-data valid pulse
- a_rdata  out  DATA_W  read data
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: identical set for master B
- mem_address  out  ADDR_W  to Memory address
- mem_load  out  1  to Memory load
- mem_in  out  DATA_W  to Memory write data
- mem_out  in  DATA_W  from Memory read data (combinational)
- lock_abort  out  1  one-cycle pulse on a forced handoff (tied 0 without the optional feature)

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE; rr pointer favours A.
  - a_gnt=b_gnt=0; a_rvalid=b_rvalid=0; a_rdata=b_rdata=0.
  - mem_address=0, mem_load=0, mem_in=0; lock_abort=0; timeout counter=0.
- FSM states: IDLE, OWN_A, OWN_B. Grants are Moore outputs: a_gnt = (state==OWN_A), b_gnt = (state==OWN_B).
- From IDLE:
  - Only one req → go to that OWN_x.
  - Both req → go to the master not served last. After reset this is A.
  - No req → stay in IDLE.
  - Grant latency: req high in cycle N → gnt high in cycle N+1, first access in N+1.
- In OWN_x, every cycle with req_x=1 is one access:
  - mem_address = x_addr, mem_in = x_wdata, mem_load = x_req & x_we (combinational mux on state).
  - With no req_x, or in IDLE: mem_load=0, mem_address=0, mem_in=0.
- Transitions out of OWN_x, evaluated at each edge:
  - req_x & (lock_x | ~req_y) → stay in OWN_x.
  - Otherwise, req_y → go to OWN_y (direct handoff, no IDLE bubble).
  - Otherwise → go to IDLE.
  - The rr pointer records x as last served when leaving OWN_x.
- Reads: on the edge ending a read cycle of x, mem_out is captured into x_rdata and x_rvalid=1 for exactly one cycle. x_rdata holds its value until the next read by x. Read latency is 1 cycle after the access cycle.
- Writes complete at the edge ending the access cycle; no acknowledge beyond gnt.
- Unlocked contention alternates A, B, A, B with one access per grant.
- Reset asserted mid-access or mid-lock: mem_load drops immediately (asynchronously, since it is derived from state); no partial write is issued after reset; a pending rvalid is lost.

Optional Feature:
- Macro: ARB_LOCK_TIMEOUT_EN.
- Defined:
  - A 4-bit-min counter increments each cycle in OWN_x while lock_x & req_y are both high; it clears on any state change or when req_y=0.
  - When the count reaches LOCK_MAX, the next edge forces OWN_y regardless of lock_x, and lock_abort pulses 1 for that cycle.
- Undefined: a lock is honoured indefinitely; lock_abort is constant 0; no counter logic is present.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, OWN_A, OWN_B}.
  - ADDR_W/DATA_W defaults.
  - MMIO_BASE = 16'h1FF0 (for benches).
  - Default LOCK_MAX.
- One sub-module, mem_arb_port_mux: combinational selection of addr/wdata/we/req by state. The FSM, rr pointer, read capture and timeout stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-write with a_gnt high → mem_load=0 at once; all grants, rvalids and rdata are 0; after release, first contention goes to A.
- Single master: A writes 0xBEEF to 0x1FFC, then reads 0x1FFC → a_gnt rises 1 cycle after a_req; mem_load=1 only in the write cycle; a_rvalid pulses 1 cycle after the read cycle with a_rdata=0xBEEF.
- Contention, no lock: A and B both hold req for 6 cycles → grants alternate A,B,A,B,A,B with no idle cycles; mem_address follows the owner's address each cycle.
- Lock: A holds lock for a 4-word burst to 0x0100–0x0103 while B requests → B is granted exactly on the cycle after A drops lock; B wait is 4 cycles.
- Timeout (ARB_LOCK_TIMEOUT_EN, LOCK_MAX=15): A locks indefinitely while B requests → after 15 cycles the grant moves to B; lock_abort=1 for one cycle; without the macro A keeps the grant for a 40-cycle run.
- Idle release: B performs a single read of 0x1FF3 returning 0xBF03 then drops req → state returns to IDLE; mem_load=0 and mem_address=0 the next cycle.
